// File: rtl/bmf_block_normalize.sv
// bmf_block_normalize: buffers one block of BLOCK minifloats, tracks the
// largest per-element exponent overflow while loading, then streams each
// element back out normalised against that shared overflow (subtract mode)
// or re-biased by a common amount with saturation (add mode).
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake, one word per cycle during LOAD
//   in_data              {ovf, sign, exp, sig}
//   in_mode, in_adj      block mode (0 = normalise, 1 = add) and add amount,
//                        taken from the block's first word
//   out_valid/out_ready  output handshake, one element per cycle during EMIT
//   out_data             {sign, exp, sig}
//   out_last             final element of the block
//   out_shift            block overflow max (normalise) or add amount (add)
//   out_sat              add mode: element exponent saturated
module bmf_block_normalize #(
  parameter int unsigned NEXP  = 2,
  parameter int unsigned NSIG  = 5,
  parameter int unsigned BLOCK = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*NEXP+NSIG:0]       in_data,
  input  logic                       in_mode,
  input  logic [NEXP-1:0]            in_adj,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEXP+NSIG:0]         out_data,
  output logic                       out_last,
  output logic [NEXP-1:0]            out_shift,
  output logic                       out_sat
);

  localparam int unsigned SIZE = 1 + NEXP + NSIG;
  localparam int unsigned IW   = NEXP + SIZE;
  localparam int unsigned CW   = (BLOCK > 1) ? $clog2(BLOCK) : 1;

  localparam logic [0:0]      S_LOAD   = 1'b0;
  localparam logic [0:0]      S_EMIT   = 1'b1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(BLOCK - 1);
  localparam logic [NEXP-1:0] EXP_MAX  = '1;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [NEXP-1:0] ovf_max_q, ovf_max_d;
  logic            mode_q, mode_d;
  logic [NEXP-1:0] adj_q, adj_d;
  logic [IW-1:0]   mem_q [BLOCK];

  logic            in_fire;
  logic            out_fire;
  logic [NEXP-1:0] in_ovf;

  // Handshake qualifiers; in_ready is held low during reset.
  always_comb begin
    in_ready  = (state_q == S_LOAD) && !rst;
    out_valid = (state_q == S_EMIT);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    in_ovf    = in_data[IW-1 -: NEXP];
  end

  // Next-state: load counter, running overflow max, emit counter.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    ovf_max_d = ovf_max_q;
    mode_d    = mode_q;
    adj_d     = adj_q;
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          wcnt_d = wcnt_q + CW'(1);
          // First word seeds the max and carries the block's mode/adj.
          if (wcnt_q == '0) begin
            ovf_max_d = in_ovf;
            mode_d    = in_mode;
            adj_d     = in_adj;
          end else if (in_ovf > ovf_max_q) begin
            ovf_max_d = in_ovf;
          end
          if (wcnt_q == LAST_IDX) begin
            wcnt_d  = '0;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_fire) begin
          rcnt_d = rcnt_q + CW'(1);
          if (rcnt_q == LAST_IDX) begin
            rcnt_d    = '0;
            ovf_max_d = '0;
            state_d   = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      ovf_max_q <= '0;
      mode_q    <= 1'b0;
      adj_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      ovf_max_q <= ovf_max_d;
      mode_q    <= mode_d;
      adj_q     <= adj_d;
    end
  end

  // Element buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wcnt_q] <= in_data;
    end
  end

  logic [IW-1:0]   rd_word;
  logic [NEXP-1:0] el_ovf;
  logic            el_sign;
  logic [NEXP-1:0] el_exp;
  logic [NSIG-1:0] el_sig;
  logic [NEXP-1:0] diff;
  logic [NEXP-1:0] sh;
  logic [NEXP:0]   sum;
  logic [NEXP-1:0] exp_res;
  logic [NSIG-1:0] sig_res;
  logic            sat_res;

  // Per-element normalise / re-bias of the element at the read pointer.
  always_comb begin
    rd_word = mem_q[rcnt_q];
    el_ovf  = rd_word[IW-1 -: NEXP];
    el_sign = rd_word[SIZE-1];
    el_exp  = rd_word[NSIG +: NEXP];
    el_sig  = rd_word[NSIG-1:0];
    diff    = ovf_max_q - el_ovf;
    sh      = diff - el_exp;
    sum     = {1'b0, el_exp} + {1'b0, adj_q};
    exp_res = el_exp;
    sig_res = el_sig;
    sat_res = 1'b0;
    if (mode_q) begin
      // Carry out of the widened sum means the exponent overflowed.
      if (sum[NEXP]) begin
        exp_res = EXP_MAX;
        sat_res = 1'b1;
      end else begin
        exp_res = sum[NEXP-1:0];
      end
    end else if (diff >= el_exp) begin
      // Element underflows to exponent zero; the remaining shift goes into sig.
      exp_res = '0;
      sig_res = (32'(sh) >= NSIG) ? '0 : (el_sig >> sh);
    end else begin
      exp_res = el_exp - diff;
    end
  end

  // Output view; data/sat/last read as zero outside EMIT.
  always_comb begin
    out_data  = out_valid ? {el_sign, exp_res, sig_res} : '0;
    out_sat   = out_valid && sat_res;
    out_last  = out_valid && (rcnt_q == LAST_IDX);
    out_shift = mode_q ? adj_q : ovf_max_q;
  end

endmodule

// File: tb/tb_bmf_block_normalize.sv
// Testbench for bmf_block_normalize: behavioural block model with a
// per-cycle compare process, directed literal checks and random blocks.
module tb_bmf_block_normalize;

  localparam int unsigned NEXP  = 2;
  localparam int unsigned NSIG  = 5;
  localparam int unsigned BLOCK = 4;
  localparam int          EMAX  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_last, out_sat;
  logic [9:0] in_data;
  logic [1:0] in_adj, out_shift;
  logic [7:0] out_data;

  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_last, b_out_sat;
  logic [11:0] b_in_data;
  logic [2:0]  b_in_adj, b_out_shift;
  logic [8:0]  b_out_data;

  bmf_block_normalize #(.NEXP(NEXP), .NSIG(NSIG), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_adj(in_adj),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_shift(out_shift), .out_sat(out_sat)
  );

  bmf_block_normalize #(.NEXP(3), .NSIG(5), .BLOCK(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_adj(b_in_adj),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_shift(b_out_shift), .out_sat(b_out_sat)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by main

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] shift;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_q[$];
  int   ld_ovf[$], ld_sign[$], ld_exp[$], ld_sig[$];
  int   ld_mode, ld_adj;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    assert_cnt++;
    if (act !== expv) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Expected output sequence of a fully loaded block, from the arithmetic rules.
  function automatic void build_block();
    int mx = 0;
    int d, e, s, sat, t, shf;
    exp_t x;
    foreach (ld_ovf[i]) if (ld_ovf[i] > mx) mx = ld_ovf[i];
    for (int i = 0; i < int'(BLOCK); i++) begin
      e = ld_exp[i]; s = ld_sig[i]; sat = 0;
      if (ld_mode == 0) begin
        d = mx - ld_ovf[i];
        if (d >= ld_exp[i]) begin
          e = 0;
          s = ld_sig[i] >> (d - ld_exp[i]);
        end else begin
          e = ld_exp[i] - d;
        end
        shf = mx;
      end else begin
        t = ld_exp[i] + ld_adj;
        if (t > EMAX) begin e = EMAX; sat = 1; end
        else e = t;
        shf = ld_adj;
      end
      x.data  = 8'(ld_sign[i] * 128 + e * 32 + s);
      x.last  = (i == int'(BLOCK) - 1);
      x.shift = 2'(shf);
      x.sat   = 1'(sat);
      exp_q.push_back(x);
    end
  endfunction

  // Per-cycle compare, then account for the handshakes of the coming edge.
  always @(negedge clk) begin
    exp_t g;
    chk("in_ready", 32'(in_ready), 32'(!rst && exp_q.size() == 0));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (out_valid && exp_q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(exp_q[0].data));
      chk("out_last", 32'(out_last), 32'(exp_q[0].last));
      chk("out_shift", 32'(out_shift), 32'(exp_q[0].shift));
      chk("out_sat", 32'(out_sat), 32'(exp_q[0].sat));
    end
    if (rst) begin
      exp_q.delete();
      ld_ovf.delete(); ld_sign.delete(); ld_exp.delete(); ld_sig.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        g.data = out_data; g.last = out_last; g.shift = out_shift; g.sat = out_sat;
        got_q.push_back(g);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (ld_ovf.size() == 0) begin
          ld_mode = int'(in_mode);
          ld_adj  = int'(in_adj);
        end
        ld_ovf.push_back(int'(in_data[9:8]));
        ld_sign.push_back(int'(in_data[7]));
        ld_exp.push_back(int'(in_data[6:5]));
        ld_sig.push_back(int'(in_data[4:0]));
        if (ld_ovf.size() == int'(BLOCK)) begin
          build_block();
          ld_ovf.delete(); ld_sign.delete(); ld_exp.delete(); ld_sig.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Present one word and hold it until accepted; returns at posedge+1.
  task automatic send_word(input logic [9:0] w, input logic m, input logic [1:0] a);
    int n = 0;
    in_valid = 1'b1; in_data = w; in_mode = m; in_adj = a;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 100) begin
        assert_cnt++; fail_cnt++;
        $display("FAIL send_word: in_ready stuck at 0 (got 0 expected 1)");
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  // Non-first words carry random mode/adj, which must be ignored.
  task automatic send_words(input logic [9:0] w [4], input logic m, input logic [1:0] a, input bit gaps);
    for (int i = 0; i < int'(BLOCK); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = 10'($urandom);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      if (i == 0) send_word(w[i], m, a);
      else send_word(w[i], 1'($urandom), 2'($urandom));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) break;
      n++;
      if (n > 300) begin
        assert_cnt++; fail_cnt++;
        $display("FAIL wait_idle: out_valid still %0b expected 0", out_valid);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_got(input string nm, input int idx, input logic [7:0] d, input logic l,
                         input logic [1:0] sh, input logic st);
    if (idx >= got_q.size()) begin
      assert_cnt++; fail_cnt++;
      $display("FAIL %s: element %0d missing (got %0d elements, expected more)", nm, idx, got_q.size());
    end else begin
      chk({nm, ".data"}, 32'(got_q[idx].data), 32'(d));
      chk({nm, ".last"}, 32'(got_q[idx].last), 32'(l));
      chk({nm, ".shift"}, 32'(got_q[idx].shift), 32'(sh));
      chk({nm, ".sat"}, 32'(got_q[idx].sat), 32'(st));
    end
  endtask

  logic [9:0] t1 [4];
  logic [9:0] t2 [4];
  logic [9:0] ta [4];
  logic [9:0] tb [4];
  logic [9:0] tr [4];

  initial begin
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_adj = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_in_adj = '0; b_out_ready = 1'b1;

    t1 = '{{2'd0, 1'b1, 2'd1, 5'b10110}, {2'd1, 1'b0, 2'd3, 5'b01010},
           {2'd3, 1'b0, 2'd2, 5'b11001}, {2'd2, 1'b0, 2'd3, 5'b00111}};
    t2 = '{{2'd3, 1'b0, 2'd3, 5'd1}, {2'd0, 1'b0, 2'd1, 5'd2},
           {2'd1, 1'b0, 2'd0, 5'd3}, {2'd2, 1'b0, 2'd2, 5'd4}};
    ta = '{{2'd3, 1'b0, 2'd1, 5'd0}, {2'd3, 1'b0, 2'd2, 5'd0},
           {2'd3, 1'b0, 2'd3, 5'd0}, {2'd3, 1'b0, 2'd0, 5'd0}};
    tb = '{{2'd1, 1'b0, 2'd2, 5'b10000}, {2'd0, 1'b0, 2'd1, 5'b00100},
           {2'd2, 1'b0, 2'd1, 5'b00011}, {2'd1, 1'b1, 2'd3, 5'b11111}};

    // Reset values while rst is held.
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_last", 32'(out_last), 32'd0);
    chk("rst.out_shift", 32'(out_shift), 32'd0);
    chk("rst.out_sat", 32'(out_sat), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.b_out_valid", 32'(b_out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // NEXP=3: an ovf-0 element against ovf max 7 shifts its significand out.
    b_in_valid = 1'b1; b_in_data = {3'd7, 1'b0, 3'd3, 5'b10101};
    @(posedge clk); #1;
    b_in_data = {3'd0, 1'b1, 3'd0, 5'b11111};
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("n3.valid0", 32'(b_out_valid), 32'd1);
    chk("n3.in_ready0", 32'(b_in_ready), 32'd0);
    chk("n3.data0", 32'(b_out_data), 32'h075);
    chk("n3.shift0", 32'(b_out_shift), 32'd7);
    chk("n3.last0", 32'(b_out_last), 32'd0);
    @(negedge clk);
    chk("n3.data1", 32'(b_out_data), 32'h100);
    chk("n3.last1", 32'(b_out_last), 32'd1);
    chk("n3.sat1", 32'(b_out_sat), 32'd0);
    @(negedge clk);
    chk("n3.valid_end", 32'(b_out_valid), 32'd0);
    chk("n3.in_ready_end", 32'(b_in_ready), 32'd1);
    @(posedge clk); #1;

    // Subtract block, always ready.
    got_q.delete();
    send_words(t1, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    chk_got("sub0", 0, 8'h85, 1'b0, 2'd3, 1'b0);
    chk_got("sub1", 1, 8'h2A, 1'b0, 2'd3, 1'b0);
    chk_got("sub2", 2, 8'h59, 1'b0, 2'd3, 1'b0);
    chk_got("sub3", 3, 8'h47, 1'b1, 2'd3, 1'b0);

    // Add mode with saturation.
    got_q.delete();
    send_words(t2, 1'b1, 2'd2, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    chk_got("add0", 0, 8'h61, 1'b0, 2'd2, 1'b1);
    chk_got("add1", 1, 8'h62, 1'b0, 2'd2, 1'b0);
    chk_got("add2", 2, 8'h43, 1'b0, 2'd2, 1'b0);
    chk_got("add3", 3, 8'h64, 1'b1, 2'd2, 1'b1);

    // Backpressure on the second element.
    got_q.delete();
    ready_mode = 2; out_ready = 1'b0;
    send_words(t1, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b1; in_data = t2[0];
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp.data", 32'(out_data), 32'h2A);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    in_valid = 1'b0;
    wait_idle();
    ready_mode = 0;
    chk_got("bp1", 1, 8'h2A, 1'b0, 2'd3, 1'b0);
    chk_got("bp2", 2, 8'h59, 1'b0, 2'd3, 1'b0);
    chk_got("bp3", 3, 8'h47, 1'b1, 2'd3, 1'b0);

    // Reset after two words of a block discards them.
    send_word({2'd3, 1'b0, 2'd1, 5'd9}, 1'b0, 2'd0);
    send_word({2'd3, 1'b0, 2'd2, 5'd7}, 1'b1, 2'd1);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rl.in_ready", 32'(in_ready), 32'd1);
    chk("rl.out_valid", 32'(out_valid), 32'd0);
    chk("rl.out_shift", 32'(out_shift), 32'd0);
    @(posedge clk); #1;
    got_q.delete();
    send_words(t1, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    chk_got("rl0", 0, 8'h85, 1'b0, 2'd3, 1'b0);
    chk_got("rl3", 3, 8'h47, 1'b1, 2'd3, 1'b0);

    // Reset during EMIT returns to an empty LOAD.
    ready_mode = 2; out_ready = 1'b0;
    send_words(t2, 1'b1, 2'd2, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("re.out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("re.out_valid_after", 32'(out_valid), 32'd0);
    chk("re.in_ready_after", 32'(in_ready), 32'd1);
    chk("re.out_shift_after", 32'(out_shift), 32'd0);
    ready_mode = 0;
    @(posedge clk); #1;

    // Back-to-back blocks with in_valid held through EMIT.
    got_q.delete();
    send_words(ta, 1'b1, 2'd3, 1'b0);
    send_words(tb, 1'b0, 2'd1, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    chk_got("bb0", 0, 8'h60, 1'b0, 2'd3, 1'b1);
    chk_got("bb3", 3, 8'h60, 1'b1, 2'd3, 1'b0);
    chk_got("bb4", 4, 8'h30, 1'b0, 2'd2, 1'b0);
    chk_got("bb7", 7, 8'hDF, 1'b1, 2'd2, 1'b0);

    // Random blocks, random backpressure and input gaps.
    ready_mode = 1;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < int'(BLOCK); i++) tr[i] = 10'($urandom);
      send_words(tr, 1'($urandom), 2'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    wait_idle();
    ready_mode = 0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
